mem_wb_stage: RTL and testbench

- Parametrised memory-access and write-back pipeline stage: the successor to the current combinational memory/branch-resolve stage.
- Accepts one operation per handshake from EX, performs a data-RAM read or write with configurable wait states, and resolves the four conditional-branch flags.
- Presents a registered write-back bundle (data, destination, branch vector) to the WB/register-file side.
- Adds what the current stage lacks: valid/ready flow control, multi-cycle memory stall, out-of-range detection, write-to-read forwarding of store data, and registered outputs.

---
 rtl/mem_wb_stage.sv | 255 +++++++++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// Memory-access / write-back pipeline stage.
// Accepts one op per valid/ready handshake, performs a data-RAM load or store
// with configurable wait states, resolves conditional-branch flags, and
// presents a registered write-back bundle to the register-file side.
module mem_wb_stage #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned REG_W       = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              read,
  input  logic              write,
  input  logic              wb_en,
  input  logic [REG_W-1:0]  rd,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic              zero,
  input  logic              carry,
  input  logic [3:0]        branch,
  output logic              out_valid,
  output logic              out_wb_en,
  output logic [REG_W-1:0]  out_rd,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        branch_vec,
  output logic              branch_taken,
  output logic              addr_err
);

  localparam int unsigned CNT_W    = 4;
  localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit          HAS_WAIT = (WAIT_STATES != 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               complete;
  logic               accept;

  // Operand latch, used while the op waits in BUSY
  logic               op_read_q,   op_read_d;
  logic               op_write_q,  op_write_d;
  logic               op_wb_q,     op_wb_d;
  logic [REG_W-1:0]   op_rd_q,     op_rd_d;
  logic [DATA_W-1:0]  op_alu_q,    op_alu_d;
  logic [DATA_W-1:0]  op_sd_q,     op_sd_d;
  logic               op_zero_q,   op_zero_d;
  logic               op_carry_q,  op_carry_d;
  logic [3:0]         op_branch_q, op_branch_d;

  // Registered write-back bundle
  logic               out_valid_q, out_valid_d;
  logic               out_wb_en_q, out_wb_en_d;
  logic [REG_W-1:0]   out_rd_q,    out_rd_d;
  logic [DATA_W-1:0]  out_data_q,  out_data_d;
  logic [3:0]         vec_q,       vec_d;
  logic               taken_q,     taken_d;
  logic               err_q,       err_d;

  // Operation currently being resolved: live inputs in IDLE, latch in BUSY
  logic               cur_read, cur_write, cur_wb, cur_zero, cur_carry;
  logic [REG_W-1:0]   cur_rd;
  logic [DATA_W-1:0]  cur_alu, cur_sd;
  logic [3:0]         cur_branch;
  logic [ADDR_W-1:0]  cur_addr;
  logic [IDX_W-1:0]   mem_idx;
  logic               cur_mem, cur_oor;
  logic [DATA_W-1:0]  mem_rdata;
  logic               mem_we;

  logic [DATA_W-1:0]  mem [DEPTH];

  // Select the op source and decode address range
  always_comb begin
    if (state_q == IDLE) begin
      cur_read   = read;
      cur_write  = write;
      cur_wb     = wb_en;
      cur_rd     = rd;
      cur_alu    = alu_result;
      cur_sd     = store_data;
      cur_zero   = zero;
      cur_carry  = carry;
      cur_branch = branch;
    end else begin
      cur_read   = op_read_q;
      cur_write  = op_write_q;
      cur_wb     = op_wb_q;
      cur_rd     = op_rd_q;
      cur_alu    = op_alu_q;
      cur_sd     = op_sd_q;
      cur_zero   = op_zero_q;
      cur_carry  = op_carry_q;
      cur_branch = op_branch_q;
    end
    cur_addr = cur_alu[ADDR_W-1:0];
    mem_idx  = cur_addr[IDX_W-1:0];
    cur_mem  = cur_read | cur_write;
    cur_oor  = 32'(cur_addr) >= DEPTH;
  end

  assign accept    = in_valid & in_ready;
  assign mem_rdata = mem[mem_idx];
  // Reset gating keeps a store from committing while rst_n is held low
  assign mem_we    = complete & cur_write & ~cur_oor & rst_n;

  // State, wait counter and operand latch registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_read_q   <= 1'b0;
      op_write_q  <= 1'b0;
      op_wb_q     <= 1'b0;
      op_rd_q     <= '0;
      op_alu_q    <= '0;
      op_sd_q     <= '0;
      op_zero_q   <= 1'b0;
      op_carry_q  <= 1'b0;
      op_branch_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_read_q   <= op_read_d;
      op_write_q  <= op_write_d;
      op_wb_q     <= op_wb_d;
      op_rd_q     <= op_rd_d;
      op_alu_q    <= op_alu_d;
      op_sd_q     <= op_sd_d;
      op_zero_q   <= op_zero_d;
      op_carry_q  <= op_carry_d;
      op_branch_q <= op_branch_d;
    end
  end

  // Next state, wait counter and completion strobe
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (cur_mem && HAS_WAIT) begin
            state_d = BUSY;
            cnt_d   = CNT_W'(WAIT_STATES);
          end else begin
            complete = 1'b1;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = IDLE;
          complete = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture operands on acceptance
  always_comb begin
    op_read_d   = op_read_q;
    op_write_d  = op_write_q;
    op_wb_d     = op_wb_q;
    op_rd_d     = op_rd_q;
    op_alu_d    = op_alu_q;
    op_sd_d     = op_sd_q;
    op_zero_d   = op_zero_q;
    op_carry_d  = op_carry_q;
    op_branch_d = op_branch_q;
    if (state_q == IDLE && accept) begin
      op_read_d   = read;
      op_write_d  = write;
      op_wb_d     = wb_en;
      op_rd_d     = rd;
      op_alu_d    = alu_result;
      op_sd_d     = store_data;
      op_zero_d   = zero;
      op_carry_d  = carry;
      op_branch_d = branch;
    end
  end

  // Handshake and next write-back bundle; branch vector reads 0 between pulses
  always_comb begin
    in_ready    = (state_q == IDLE);
    out_valid_d = complete;
    out_wb_en_d = out_wb_en_q;
    out_rd_d    = out_rd_q;
    out_data_d  = out_data_q;
    err_d       = err_q;
    vec_d       = '0;
    taken_d     = 1'b0;
    if (complete) begin
      out_wb_en_d = cur_wb;
      out_rd_d    = cur_rd;
      err_d       = cur_mem & cur_oor;
      if (cur_write) begin
        out_data_d = cur_sd;
      end else if (cur_read) begin
        out_data_d = cur_oor ? '0 : mem_rdata;
      end else begin
        out_data_d = cur_alu;
      end
      vec_d   = {cur_branch[3] &  cur_zero,  cur_branch[2] & ~cur_zero,
                 cur_branch[1] &  cur_carry, cur_branch[0] & ~cur_carry};
      taken_d = |vec_d;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_wb_en_q <= 1'b0;
      out_rd_q    <= '0;
      out_data_q  <= '0;
      vec_q       <= '0;
      taken_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_wb_en_q <= out_wb_en_d;
      out_rd_q    <= out_rd_d;
      out_data_q  <= out_data_d;
      vec_q       <= vec_d;
      taken_q     <= taken_d;
      err_q       <= err_d;
    end
  end

  // Data RAM write port; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= cur_sd;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_wb_en    = out_wb_en_q;
  assign out_rd       = out_rd_q;
  assign out_data     = out_data_q;
  assign branch_vec   = vec_q;
  assign branch_taken = taken_q;
  assign addr_err     = err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: four instances cover
// W=0/DEPTH=256, W=2, W=0/DEPTH=16 and W=3 with reset during BUSY.
module tb_mem_wb_stage;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n [N];
  logic       in_valid [N];
  logic       in_ready [N];
  logic       rd_en [N];
  logic       wr_en [N];
  logic       wb_en [N];
  logic [2:0] rd [N];
  logic [7:0] alu [N];
  logic [7:0] sd [N];
  logic       zero [N];
  logic       carry [N];
  logic [3:0] branch [N];
  logic       out_valid [N];
  logic       out_wb_en [N];
  logic [2:0] out_rd [N];
  logic [7:0] out_data [N];
  logic [3:0] branch_vec [N];
  logic       branch_taken [N];
  logic       addr_err [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_wb_stage #(
      .DATA_W      (8),
      .ADDR_W      (8),
      .DEPTH       ((g == 2) ? 16 : 256),
      .WAIT_STATES ((g == 1) ? 2 : (g == 3) ? 3 : 0),
      .REG_W       (3)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n[g]),
      .in_valid     (in_valid[g]),
      .in_ready     (in_ready[g]),
      .read         (rd_en[g]),
      .write        (wr_en[g]),
      .wb_en        (wb_en[g]),
      .rd           (rd[g]),
      .alu_result   (alu[g]),
      .store_data   (sd[g]),
      .zero         (zero[g]),
      .carry        (carry[g]),
      .branch       (branch[g]),
      .out_valid    (out_valid[g]),
      .out_wb_en    (out_wb_en[g]),
      .out_rd       (out_rd[g]),
      .out_data     (out_data[g]),
      .branch_vec   (branch_vec[g]),
      .branch_taken (branch_taken[g]),
      .addr_err     (addr_err[g])
    );
  end

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op on instance k; branch fields cleared, wb_en set for non-stores
  task automatic op(input int k, input logic v, input logic r, input logic w,
                    input logic [2:0] ri, input logic [7:0] a, input logic [7:0] s);
    in_valid[k] = v;
    rd_en[k]    = r;
    wr_en[k]    = w;
    wb_en[k]    = ~w;
    rd[k]       = ri;
    alu[k]      = a;
    sd[k]       = s;
    zero[k]     = 1'b0;
    carry[k]    = 1'b0;
    branch[k]   = 4'b0000;
  endtask

  task automatic br(input int k, input logic z, input logic c, input logic [3:0] b);
    zero[k]   = z;
    carry[k]  = c;
    branch[k] = b;
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      rst_n[k] = 1'b0;
      op(k, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    end
    tick();
    tick();
    for (int k = 0; k < N; k++) begin
      check($sformatf("rst_ready%0d", k), 32'(in_ready[k]), 32'h1);
      check($sformatf("rst_valid%0d", k), 32'(out_valid[k]), 32'h0);
      check($sformatf("rst_data%0d", k), 32'(out_data[k]), 32'h0);
      rst_n[k] = 1'b1;
    end
    tick();

    // W=0: store then load same address on the next cycle
    op(0, 1'b1, 1'b0, 1'b1, 3'd0, 8'h10, 8'h5A); tick();
    check("w0_st_valid", 32'(out_valid[0]), 32'h1);
    check("w0_st_data", 32'(out_data[0]), 32'h5A);
    check("w0_st_wb", 32'(out_wb_en[0]), 32'h0);
    check("w0_st_err", 32'(addr_err[0]), 32'h0);
    op(0, 1'b1, 1'b1, 1'b0, 3'd5, 8'h10, 8'h00); tick();
    check("w0_ld_valid", 32'(out_valid[0]), 32'h1);
    check("w0_ld_data", 32'(out_data[0]), 32'h5A);
    check("w0_ld_rd", 32'(out_rd[0]), 32'h5);
    check("w0_ld_wb", 32'(out_wb_en[0]), 32'h1);
    check("w0_ld_err", 32'(addr_err[0]), 32'h0);
    op(0, 1'b1, 1'b0, 1'b0, 3'd3, 8'h33, 8'h00); tick();
    check("w0_alu_data", 32'(out_data[0]), 32'h33);
    check("w0_alu_rd", 32'(out_rd[0]), 32'h3);
    op(0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00); tick();
    check("w0_idle_valid", 32'(out_valid[0]), 32'h0);
    check("w0_idle_hold", 32'(out_data[0]), 32'h33);
    check("w0_idle_ready", 32'(in_ready[0]), 32'h1);
    // read+write together behaves as a store with forwarding
    op(0, 1'b1, 1'b1, 1'b1, 3'd1, 8'h20, 8'h99); tick();
    check("w0_rw_data", 32'(out_data[0]), 32'h99);
    op(0, 1'b1, 1'b1, 1'b0, 3'd1, 8'h20, 8'h00); tick();
    check("w0_rw_ld", 32'(out_data[0]), 32'h99);

    // Branch resolution
    op(0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00); br(0, 1'b1, 1'b0, 4'b1000); tick();
    check("br_bz_vec", 32'(branch_vec[0]), 32'h8);
    check("br_bz_tk", 32'(branch_taken[0]), 32'h1);
    op(0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00); br(0, 1'b0, 1'b1, 4'b0011); tick();
    check("br_bc_vec", 32'(branch_vec[0]), 32'h2);
    check("br_bc_tk", 32'(branch_taken[0]), 32'h1);
    op(0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00); br(0, 1'b1, 1'b0, 4'b0100); tick();
    check("br_bnz_vec", 32'(branch_vec[0]), 32'h0);
    check("br_bnz_tk", 32'(branch_taken[0]), 32'h0);
    op(0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00); br(0, 1'b0, 1'b0, 4'b1111); tick();
    check("br_all_vec", 32'(branch_vec[0]), 32'h5);
    check("br_all_tk", 32'(branch_taken[0]), 32'h1);
    op(0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00); tick();

    // W=2: preload 0x5A @0x10
    op(1, 1'b1, 1'b0, 1'b1, 3'd0, 8'h10, 8'h5A); tick();
    op(1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00); tick(); tick();
    check("w2_pre_valid", 32'(out_valid[1]), 32'h1);
    // load accepted at cycle 0, next store held on in_valid
    op(1, 1'b1, 1'b1, 1'b0, 3'd4, 8'h10, 8'h00); tick();
    check("w2_c1_ready", 32'(in_ready[1]), 32'h0);
    check("w2_c1_valid", 32'(out_valid[1]), 32'h0);
    op(1, 1'b1, 1'b0, 1'b1, 3'd0, 8'h11, 8'h66); tick();
    check("w2_c2_ready", 32'(in_ready[1]), 32'h0);
    check("w2_c2_valid", 32'(out_valid[1]), 32'h0);
    tick();
    check("w2_c3_valid", 32'(out_valid[1]), 32'h1);
    check("w2_c3_data", 32'(out_data[1]), 32'h5A);
    check("w2_c3_rd", 32'(out_rd[1]), 32'h4);
    check("w2_c3_ready", 32'(in_ready[1]), 32'h1);
    tick();
    op(1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    check("w2_c4_ready", 32'(in_ready[1]), 32'h0);
    check("w2_c4_valid", 32'(out_valid[1]), 32'h0);
    check("w2_c4_hold", 32'(out_data[1]), 32'h5A);
    tick();
    check("w2_c5_valid", 32'(out_valid[1]), 32'h0);
    tick();
    check("w2_c6_valid", 32'(out_valid[1]), 32'h1);
    check("w2_c6_data", 32'(out_data[1]), 32'h66);

    // DEPTH=16: out-of-range handling
    op(2, 1'b1, 1'b0, 1'b1, 3'd0, 8'h00, 8'h11); tick();
    op(2, 1'b1, 1'b0, 1'b1, 3'd0, 8'h20, 8'hFF); tick();
    check("d16_st_valid", 32'(out_valid[2]), 32'h1);
    check("d16_st_err", 32'(addr_err[2]), 32'h1);
    op(2, 1'b1, 1'b1, 1'b0, 3'd2, 8'h00, 8'h00); tick();
    check("d16_ld0_data", 32'(out_data[2]), 32'h11);
    check("d16_ld0_err", 32'(addr_err[2]), 32'h0);
    op(2, 1'b1, 1'b1, 1'b0, 3'd2, 8'h10, 8'h00); tick();
    check("d16_ld10_data", 32'(out_data[2]), 32'h0);
    check("d16_ld10_err", 32'(addr_err[2]), 32'h1);
    op(2, 1'b1, 1'b1, 1'b0, 3'd2, 8'h20, 8'h00); tick();
    check("d16_ld20_data", 32'(out_data[2]), 32'h0);
    check("d16_ld20_err", 32'(addr_err[2]), 32'h1);
    op(2, 1'b1, 1'b0, 1'b1, 3'd0, 8'h0F, 8'h3C); tick();
    op(2, 1'b1, 1'b1, 1'b0, 3'd2, 8'h0F, 8'h00); tick();
    check("d16_ldF_data", 32'(out_data[2]), 32'h3C);
    check("d16_ldF_err", 32'(addr_err[2]), 32'h0);
    op(2, 1'b1, 1'b0, 1'b0, 3'd2, 8'h20, 8'h00); tick();
    check("d16_alu_err", 32'(addr_err[2]), 32'h0);
    check("d16_alu_data", 32'(out_data[2]), 32'h20);
    op(2, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00); tick();

    // W=3: preload 0x44 @0x05, then abort a store with reset during BUSY
    op(3, 1'b1, 1'b0, 1'b1, 3'd0, 8'h05, 8'h44); tick();
    op(3, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00); tick(); tick(); tick();
    check("w3_pre_valid", 32'(out_valid[3]), 32'h1);
    check("w3_pre_data", 32'(out_data[3]), 32'h44);
    tick();
    op(3, 1'b1, 1'b0, 1'b1, 3'd0, 8'h05, 8'h77); tick();
    check("w3_busy_ready", 32'(in_ready[3]), 32'h0);
    op(3, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00); tick();
    #2 rst_n[3] = 1'b0;
    #1;
    check("w3_arst_ready", 32'(in_ready[3]), 32'h1);
    check("w3_arst_valid", 32'(out_valid[3]), 32'h0);
    check("w3_arst_data", 32'(out_data[3]), 32'h0);
    tick();
    tick();
    check("w3_abort_valid", 32'(out_valid[3]), 32'h0);
    rst_n[3] = 1'b1;
    tick();
    check("w3_post_valid", 32'(out_valid[3]), 32'h0);
    op(3, 1'b1, 1'b1, 1'b0, 3'd2, 8'h05, 8'h00); tick();
    op(3, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00); tick(); tick();
    check("w3_ld_early", 32'(out_valid[3]), 32'h0);
    tick();
    check("w3_ld_valid", 32'(out_valid[3]), 32'h1);
    check("w3_ld_data", 32'(out_data[3]), 32'h44);
    check("w3_ld_rd", 32'(out_rd[3]), 32'h2);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
